// File: rtl/cache_line_fill_pkg.sv
// Shared types for the line-fill controller: FSM state encoding and tag-width helper.
package cache_line_fill_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE   = 2'd0,
    FILL_FETCH  = 2'd1,
    FILL_COMMIT = 2'd2
  } fill_state_e;

  function automatic int tag_width(input int addr_w, input int line_off_w, input int word_off_w);
    return addr_w - line_off_w - word_off_w;
  endfunction

endpackage

// File: rtl/cache_line_fill.sv
// Miss-handling line-fill controller: invalidates the victim way, streams a whole line
// from back-end memory into its data memory, then commits the tag and updates replacement.
//
// state       | meaning
// FILL_IDLE   | ready for a miss; accept latches tag/line/way and invalidates the victim tag
// FILL_FETCH  | one back-end read per word, word 0 first, data written as each beat completes
// FILL_COMMIT | single cycle: tag/valid written, replacement update and done pulsed
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int N_WAYS     = 4,
  parameter int NWAY_W     = $clog2(N_WAYS),
  parameter int LINE_OFF_W = 7,
  parameter int WORD_OFF_W = 3,
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  input  logic [ADDR_W-1:0]                    req_addr,
  output logic                                 req_ready,
  input  logic [N_WAYS-1:0]                    way_select,
  output logic                                 mem_valid,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [DATA_W-1:0]                    mem_rdata,
  input  logic                                 mem_ready,
  output logic [N_WAYS-1:0]                    data_we,
  output logic [LINE_OFF_W+WORD_OFF_W-1:0]     data_addr,
  output logic [DATA_W-1:0]                    data_wdata,
  output logic [N_WAYS-1:0]                    tag_we,
  output logic [LINE_OFF_W-1:0]                tag_line,
  output logic [ADDR_W-LINE_OFF_W-WORD_OFF_W-1:0] tag_wdata,
  output logic                                 tag_valid,
  output logic                                 repl_write_en,
  output logic [N_WAYS-1:0]                    repl_way_hit,
  output logic                                 done
);

  localparam int TAG_W = tag_width(ADDR_W, LINE_OFF_W, WORD_OFF_W);

  fill_state_e             state_q, state_d;
  logic [WORD_OFF_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]        tag_q;
  logic [LINE_OFF_W-1:0]   line_q;
  logic [NWAY_W-1:0]       way_idx_q;
  logic [NWAY_W-1:0]       way_idx_sel;
  logic [N_WAYS-1:0]       way_oh_q;
  logic [N_WAYS-1:0]       way_oh_sel;
  logic [TAG_W-1:0]        req_tag;
  logic [LINE_OFF_W-1:0]   req_line;
  logic                    accept;
  logic                    unused_word_off;

  assign req_tag         = req_addr[ADDR_W-1 -: TAG_W];
  assign req_line        = req_addr[WORD_OFF_W +: LINE_OFF_W];
  // The fill always starts at word 0, so the missed word offset is not needed.
  assign unused_word_off = ^req_addr[WORD_OFF_W-1:0];

  // Lowest set bit wins; an empty victim vector falls back to way 0.
  always_comb begin
    way_idx_sel = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (way_select[i]) way_idx_sel = NWAY_W'(i);
    end
  end

  assign way_oh_sel = N_WAYS'(1) << way_idx_sel;
  assign way_oh_q   = N_WAYS'(1) << way_idx_q;
  assign accept     = (state_q == FILL_IDLE) && req_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL_IDLE;
      cnt_q     <= '0;
      tag_q     <= '0;
      line_q    <= '0;
      way_idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        tag_q     <= req_tag;
        line_q    <= req_line;
        way_idx_q <= way_idx_sel;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready     = 1'b0;
    mem_valid     = 1'b0;
    mem_addr      = '0;
    data_we       = '0;
    data_addr     = '0;
    data_wdata    = '0;
    tag_we        = '0;
    tag_line      = '0;
    tag_wdata     = '0;
    tag_valid     = 1'b0;
    repl_write_en = 1'b0;
    repl_way_hit  = '0;
    done          = 1'b0;

    case (state_q)
      FILL_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Invalidate first so a partially written line can never hit.
          tag_we    = way_oh_sel;
          tag_line  = req_line;
          tag_wdata = req_tag;
          tag_valid = 1'b0;
          cnt_d     = '0;
          state_d   = FILL_FETCH;
        end
      end

      FILL_FETCH: begin
        mem_valid = 1'b1;
        mem_addr  = {tag_q, line_q, cnt_q};
        data_addr = {line_q, cnt_q};
        if (mem_ready) begin
          data_we    = way_oh_q;
          data_wdata = mem_rdata;
          cnt_d      = cnt_q + WORD_OFF_W'(1);
          if (&cnt_q) state_d = FILL_COMMIT;
        end
      end

      FILL_COMMIT: begin
        tag_we        = way_oh_q;
        tag_line      = line_q;
        tag_wdata     = tag_q;
        tag_valid     = 1'b1;
        repl_write_en = 1'b1;
        repl_way_hit  = way_oh_q;
        done          = 1'b1;
        state_d       = FILL_IDLE;
      end

      default: state_d = FILL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Randomised self-checking bench for cache_line_fill against a per-request line-fill model.
module tb_cache_line_fill;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int WORDS  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic        req_ready;
  logic [3:0]  way_select = '0;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  data_we;
  logic [9:0]  data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  tag_we;
  logic [6:0]  tag_line;
  logic [13:0] tag_wdata;
  logic        tag_valid;
  logic        repl_write_en;
  logic [3:0]  repl_way_hit;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  cache_line_fill dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .way_select(way_select),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .tag_we(tag_we), .tag_line(tag_line), .tag_wdata(tag_wdata), .tag_valid(tag_valid),
    .repl_write_en(repl_write_en), .repl_way_hit(repl_way_hit), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Victim way as the policy intends it: lowest requested way, way 0 if none.
  function automatic logic [3:0] model_way(input logic [3:0] ws);
    for (int i = 0; i < 4; i++) if (ws[i]) return 4'(1 << i);
    return 4'b0001;
  endfunction

  task automatic check_idle_quiet(input string tag);
    check_eq({tag, ".req_ready"}, req_ready, 1);
    check_eq({tag, ".mem_valid"}, mem_valid, 0);
    check_eq({tag, ".data_we"}, data_we, 0);
    check_eq({tag, ".tag_we"}, tag_we, 0);
    check_eq({tag, ".repl"}, {repl_write_en, repl_way_hit}, 0);
    check_eq({tag, ".done"}, done, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept in the current (negedge-aligned) cycle and check the invalidate strobe.
  task automatic accept_req(input logic [23:0] a, input logic [3:0] ws, output int acc_cyc);
    req_valid = 1'b1; req_addr = a; way_select = ws;
    mem_ready = 1'($urandom);
    #1;
    acc_cyc = cyc;
    check_eq("acc.req_ready", req_ready, 1);
    check_eq("acc.tag_we", tag_we, model_way(ws));
    check_eq("acc.tag_line", tag_line, (a >> 3) & 24'h7f);
    check_eq("acc.tag_valid", tag_valid, 0);
    check_eq("acc.mem_valid", mem_valid, 0);
    check_eq("acc.done", done, 0);
  endtask

  task automatic beat(input logic [23:0] a, input logic [3:0] ws, input int k,
                      input int max_stall, input bit disturb, inout int stalls);
    int n;
    logic [31:0] d;
    n = $urandom_range(0, max_stall);
    for (int s = 0; s <= n; s++) begin
      if (disturb) begin
        req_valid = 1'b1; req_addr = 24'($urandom); way_select = 4'($urandom);
      end
      d = $urandom;
      mem_rdata = d;
      mem_ready = (s == n);
      #1;
      check_eq("fetch.req_ready", req_ready, 0);
      check_eq("fetch.mem_valid", mem_valid, 1);
      check_eq("fetch.mem_addr", mem_addr, (a & ~24'h7) + 24'(k));
      check_eq("fetch.tag_we", tag_we, 0);
      check_eq("fetch.done", done, 0);
      if (s == n) begin
        check_eq("beat.data_we", data_we, model_way(ws));
        check_eq("beat.data_addr", data_addr, ((a >> 3) & 24'h7f) * WORDS + 24'(k));
        check_eq("beat.data_wdata", data_wdata, d);
      end else begin
        check_eq("stall.data_we", data_we, 0);
        stalls++;
      end
      next_cycle();
    end
  endtask

  task automatic do_fill(input logic [23:0] a, input logic [3:0] ws,
                         input int max_stall, input bit disturb);
    int acc_cyc;
    int stalls;
    stalls = 0;
    accept_req(a, ws, acc_cyc);
    next_cycle();
    if (!disturb) req_valid = 1'b0;
    for (int k = 0; k < WORDS; k++) beat(a, ws, k, max_stall, disturb, stalls);
    mem_ready = 1'($urandom);
    #1;
    check_eq("commit.done", done, 1);
    check_eq("commit.latency", cyc - acc_cyc, WORDS + 1 + stalls);
    check_eq("commit.tag_we", tag_we, model_way(ws));
    check_eq("commit.tag_line", tag_line, (a >> 3) & 24'h7f);
    check_eq("commit.tag_wdata", tag_wdata, a >> 10);
    check_eq("commit.tag_valid", tag_valid, 1);
    check_eq("commit.repl_en", repl_write_en, 1);
    check_eq("commit.repl_way", repl_way_hit, model_way(ws));
    check_eq("commit.req_ready", req_ready, 0);
    check_eq("commit.mem_valid", mem_valid, 0);
    check_eq("commit.data_we", data_we, 0);
    next_cycle();
    req_valid = 1'b0;
    #1;
    check_idle_quiet("post");
  endtask

  initial begin
    int acc_cyc;
    int stalls;

    // Reset held with back-end noise.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ready = ~mem_ready;
      mem_rdata = $urandom;
      #1;
      check_idle_quiet("reset");
    end
    reset = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_idle_quiet("idle");
    end

    do_fill(24'h012345, 4'b0100, 0, 1'b0);
    next_cycle();
    do_fill(24'h3a5c17, 4'b1000, 5, 1'b0);
    next_cycle();
    do_fill(24'h00ff08, 4'b0110, 2, 1'b0);
    next_cycle();
    do_fill(24'h7fffff, 4'b0000, 0, 1'b0);
    next_cycle();
    do_fill(24'h4567c0, 4'b1001, 3, 1'b1);
    next_cycle();

    // Abandon a fill after three beats with an asynchronous reset.
    stalls = 0;
    accept_req(24'h2b2b2b, 4'b0010, acc_cyc);
    next_cycle();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) beat(24'h2b2b2b, 4'b0010, k, 0, 1'b0, stalls);
    mem_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check_idle_quiet("abort");
    next_cycle();
    check_idle_quiet("abort.hold");
    reset = 1'b1;
    mem_ready = 1'b0;
    next_cycle();
    check_idle_quiet("abort.rel");
    do_fill(24'h2b2b2b, 4'b0010, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      next_cycle();
      do_fill(24'($urandom), 4'($urandom), 5, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
